line_mem_bridge: RTL and testbench

//  Memory-side responder for the cache line port: accepts one 128-bit line read/write per mem_valid/mem_ready

---
 rtl/line_mem_bridge_pkg.sv | 26 ++
 rtl/line_mem_bridge.sv | 113 +++++++++++
 tb/tb_line_mem_bridge.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_bridge_pkg.sv
// Shared widths, state encoding and latched request payload for the line-to-word memory bridge.
package line_mem_bridge_pkg;

  localparam int unsigned LINE_W  = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 29;
  localparam int unsigned BEATS   = LINE_W / WORD_W;
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned BEAT_W  = 2;
  localparam int unsigned BADDR_W = ADDR_W - 2;
  localparam int unsigned BASE_W  = ADDR_W - OFF_W;
  localparam int unsigned RBUF_W  = LINE_W - WORD_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic              we;
    logic [LINE_W-1:0] wdata;
  } line_req_t;

endpackage

// File: rtl/line_mem_bridge.sv
// Memory-side responder: services one 128-bit line read/write as four sequential 32-bit bus beats.
module line_mem_bridge
  import line_mem_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_mem_valid,
  output logic               o_mem_ready,
  input  logic [ADDR_W-1:0]  i_mem_addr,
  input  logic               i_mem_wmask,
  input  logic [LINE_W-1:0]  i_mem_wdata,
  output logic [LINE_W-1:0]  o_mem_rdata,
  output logic               o_bus_valid,
  input  logic               i_bus_ready,
  output logic [BADDR_W-1:0] o_bus_addr,
  output logic               o_bus_we,
  output logic [WORD_W-1:0]  o_bus_wdata,
  input  logic [WORD_W-1:0]  i_bus_rdata
);

  state_t               r_state;
  logic [BEAT_W-1:0]    r_beat;
  line_req_t            r_req;
  logic [RBUF_W-1:0]    r_rbuf;
  logic                 r_mem_ready;
  logic [LINE_W-1:0]    r_mem_rdata;
  logic                 r_bus_valid;
  logic [BADDR_W-1:0]   r_bus_addr;
  logic                 r_bus_we;
  logic [WORD_W-1:0]    r_bus_wdata;

  logic [BEAT_W-1:0]    w_beat_nxt;
  logic [WORD_W-1:0]    w_word_nxt;
  logic [OFF_W-1:0]     w_unused_addr_lsb;

  // Line offset bits carry no meaning: lines are always fetched whole, low word first.
  assign w_unused_addr_lsb = i_mem_addr[OFF_W-1:0];
  assign w_beat_nxt        = r_beat + BEAT_W'(1);
  assign w_word_nxt        = r_req.wdata[WORD_W*w_beat_nxt +: WORD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_req       <= '0;
      r_rbuf      <= '0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      r_bus_valid <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mem_valid) begin
            r_req       <= '{base: i_mem_addr[ADDR_W-1:OFF_W], we: i_mem_wmask, wdata: i_mem_wdata};
            r_beat      <= '0;
            r_bus_valid <= 1'b1;
            r_bus_addr  <= {i_mem_addr[ADDR_W-1:OFF_W], BEAT_W'(0)};
            r_bus_we    <= i_mem_wmask;
            r_bus_wdata <= i_mem_wdata[WORD_W-1:0];
            r_state     <= S_BEAT;
          end
        end
        S_BEAT: begin
          if (i_bus_ready) begin
            if (!r_req.we) begin
              case (r_beat)
                2'd0:    r_rbuf[WORD_W-1:0]          <= i_bus_rdata;
                2'd1:    r_rbuf[2*WORD_W-1:WORD_W]   <= i_bus_rdata;
                2'd2:    r_rbuf[3*WORD_W-1:2*WORD_W] <= i_bus_rdata;
                default: ;
              endcase
            end
            // Last beat: the final read word goes straight into the line, not via rbuf.
            if (r_beat == BEAT_W'(BEATS - 1)) begin
              r_beat      <= '0;
              r_bus_valid <= 1'b0;
              r_bus_addr  <= '0;
              r_bus_we    <= 1'b0;
              r_bus_wdata <= '0;
              r_mem_ready <= 1'b1;
              if (!r_req.we) begin
                r_mem_rdata <= {i_bus_rdata, r_rbuf};
              end
              r_state     <= S_DONE;
            end else begin
              r_beat      <= w_beat_nxt;
              r_bus_addr  <= {r_req.base, w_beat_nxt};
              r_bus_wdata <= w_word_nxt;
            end
          end
        end
        S_DONE: begin
          r_mem_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_ready = r_mem_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_bus_valid = r_bus_valid;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_we    = r_bus_we;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_line_mem_bridge.sv
// Scoreboard bench for line_mem_bridge: word-memory reference model, randomized bus slave and requests.
module tb_line_mem_bridge;
  import line_mem_bridge_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               i_mem_valid;
  logic               o_mem_ready;
  logic [ADDR_W-1:0]  i_mem_addr;
  logic               i_mem_wmask;
  logic [LINE_W-1:0]  i_mem_wdata;
  logic [LINE_W-1:0]  o_mem_rdata;
  logic               o_bus_valid;
  logic               i_bus_ready;
  logic [BADDR_W-1:0] o_bus_addr;
  logic               o_bus_we;
  logic [WORD_W-1:0]  o_bus_wdata;
  logic [WORD_W-1:0]  i_bus_rdata;

  line_mem_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_valid (i_mem_valid),
    .o_mem_ready (o_mem_ready),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wmask (i_mem_wmask),
    .i_mem_wdata (i_mem_wdata),
    .o_mem_rdata (o_mem_rdata),
    .o_bus_valid (o_bus_valid),
    .i_bus_ready (i_bus_ready),
    .o_bus_addr  (o_bus_addr),
    .o_bus_we    (o_bus_we),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_rdata (i_bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BADDR_W-1:0] addr;
    logic               we;
    logic [WORD_W-1:0]  wdata;
  } beat_t;

  beat_t             exp_beats[$];
  logic [LINE_W-1:0] exp_rsp[$];
  logic [WORD_W-1:0] slave_mem [logic [BADDR_W-1:0]];
  logic [WORD_W-1:0] ref_mem   [logic [BADDR_W-1:0]];

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  int pulses_seen = 0;
  int waits_total = 0;
  int wait_mode = 0;
  logic [LINE_W-1:0] last_read = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Backing memory contents before any write; words 4..7 hold the known pattern.
  function automatic logic [WORD_W-1:0] init_word(input logic [BADDR_W-1:0] a);
    if (a >= 27'd4 && a <= 27'd7) return 32'h11111111 * 32'(a - 27'd3);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [WORD_W-1:0] slave_rd(input logic [BADDR_W-1:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  function automatic logic [WORD_W-1:0] ref_rd(input logic [BADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Bus slave: per-beat wait count (fixed or random), data from its own memory.
  int cnt = 0;
  int beat_wait = -1;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n || !o_bus_valid) begin
      i_bus_ready = 1'b0;
      cnt = 0;
      beat_wait = -1;
    end else begin
      if (beat_wait < 0) beat_wait = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
      if (cnt < beat_wait) begin
        i_bus_ready = 1'b0;
        i_bus_rdata = $urandom;
        cnt++;
        waits_total++;
      end else begin
        i_bus_ready = 1'b1;
        i_bus_rdata = slave_rd(o_bus_addr);
        if (o_bus_we) slave_mem[o_bus_addr] = o_bus_wdata;
        cnt = 0;
        beat_wait = -1;
      end
    end
  end

  // Bus monitor: beat order/content and stability while stalled.
  logic               stab_pend = 1'b0;
  logic [BADDR_W-1:0] stab_addr;
  logic [WORD_W-1:0]  stab_wd;
  always @(negedge clk) begin
    if (!rst_n) begin
      stab_pend = 1'b0;
    end else begin
      if (stab_pend) begin
        chk("bus_hold_addr", 128'(o_bus_addr), 128'(stab_addr));
        chk("bus_hold_wdata", 128'(o_bus_wdata), 128'(stab_wd));
        stab_pend = 1'b0;
      end
      if (o_bus_valid && i_bus_ready) begin
        beat_t b;
        beats_seen++;
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected_beat: got addr %h expected no beat", o_bus_addr);
        end else begin
          b = exp_beats.pop_front();
          chk("bus_addr", 128'(o_bus_addr), 128'(b.addr));
          chk("bus_we", 128'(o_bus_we), 128'(b.we));
          if (b.we) chk("bus_wdata", 128'(o_bus_wdata), 128'(b.wdata));
        end
      end else if (o_bus_valid) begin
        stab_pend = 1'b1;
        stab_addr = o_bus_addr;
        stab_wd   = o_bus_wdata;
      end
    end
  end

  // Line-port monitor: single-cycle completion pulse and returned line.
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready = 1'b0;
    end else begin
      if (o_mem_ready) begin
        logic [LINE_W-1:0] e;
        pulses_seen++;
        chk("mem_ready_pulse", 128'(prev_ready), 128'(0));
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected_ready: got rdata %h expected no completion", o_mem_rdata);
        end else begin
          e = exp_rsp.pop_front();
          chk("mem_rdata", o_mem_rdata, e);
        end
      end
      prev_ready = o_mem_ready;
    end
  end

  // Push the expected beats/response, then drive one request to completion.
  task automatic do_req(input logic [ADDR_W-1:0] a, input logic we, input logic [LINE_W-1:0] wd,
                        input logic chk_lat);
    logic [LINE_W-1:0] line;
    int n;
    line = '0;
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.addr  = (BADDR_W'(a >> 4) << 2) + BADDR_W'(i);
      b.we    = we;
      b.wdata = wd[32*i +: 32];
      exp_beats.push_back(b);
      if (we) ref_mem[b.addr] = b.wdata;
      else    line[32*i +: 32] = ref_rd(b.addr);
    end
    if (!we) last_read = line;
    exp_rsp.push_back(last_read);
    waits_total = 0;
    i_mem_addr  = a;
    i_mem_wmask = we;
    i_mem_wdata = wd;
    i_mem_valid = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    i_mem_addr  = ADDR_W'($urandom);
    i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
    i_mem_wmask = ~we;
    while (!o_mem_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!o_mem_ready) begin
      checks++;
      errors++;
      $display("FAIL mem_ready_timeout: got no mem_ready after %0d cycles expected completion", n);
    end else if (chk_lat) begin
      chk("latency", 128'(n), 128'(5 + waits_total));
    end
    @(posedge clk);
    #1;
    i_mem_valid = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_ready"}, 128'(o_mem_ready), 128'(0));
    chk({tag, "_mem_rdata"}, o_mem_rdata, 128'(0));
    chk({tag, "_bus_valid"}, 128'(o_bus_valid), 128'(0));
    chk({tag, "_bus_addr"}, 128'(o_bus_addr), 128'(0));
    chk({tag, "_bus_we"}, 128'(o_bus_we), 128'(0));
    chk({tag, "_bus_wdata"}, 128'(o_bus_wdata), 128'(0));
  endtask

  initial begin
    int b0, p0, k;
    rst_n       = 1'b0;
    i_mem_valid = 1'b0;
    i_mem_addr  = '0;
    i_mem_wmask = 1'b0;
    i_mem_wdata = '0;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-pattern read, then the same line via an address with offset bits set.
    wait_mode = 0;
    do_req(29'h0000010, 1'b0, '0, 1'b1);
    chk("t1_line", o_mem_rdata, 128'h44444444_33333333_22222222_11111111);
    do_req(29'h000001F, 1'b0, '0, 1'b1);
    chk("t6_line", o_mem_rdata, 128'h44444444_33333333_22222222_11111111);

    do_req(29'h1234560, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1);
    chk("t2_rdata_kept", o_mem_rdata, 128'h44444444_33333333_22222222_11111111);

    // Flush followed immediately by alloc.
    b0 = beats_seen;
    p0 = pulses_seen;
    do_req(29'h1234560, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    do_req(29'h0ABCDE0, 1'b0, '0, 1'b1);
    chk("t3_beats", 128'(beats_seen - b0), 128'(8));
    chk("t3_pulses", 128'(pulses_seen - p0), 128'(2));

    wait_mode = 3;
    do_req(29'h1234560, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    do_req(29'h0000010, 1'b0, '0, 1'b1);

    // Reset during beat 2 of a read, then a fresh read must restart at beat 0.
    wait_mode = 1;
    b0 = beats_seen;
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.addr = 27'h10 + 27'(i);
      b.we = 1'b0;
      b.wdata = '0;
      exp_beats.push_back(b);
    end
    i_mem_addr  = 29'h0000040;
    i_mem_wmask = 1'b0;
    i_mem_valid = 1'b1;
    k = 0;
    while (beats_seen < b0 + 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("t5_pre_valid", 128'(o_bus_valid), 128'(1));
    chk("t5_pre_addr", 128'(o_bus_addr), 128'(27'h12));
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t5_async");
    exp_beats.delete();
    i_mem_valid = 1'b0;
    last_read = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_mode = 0;
    do_req(29'h0000020, 1'b0, '0, 1'b1);

    // Random traffic over a small region so reads observe earlier writes.
    wait_mode = -1;
    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(29'h300 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15));
      do_req(a, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("beats_left", 128'(exp_beats.size()), 128'(0));
    chk("rsp_left", 128'(exp_rsp.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
